ula_exec_stage: RTL
===================

Name: ula_exec_stage

Overview:
- Sequential execute/writeback stage that sits directly upstream of the 8-bit combinational ULA and consumes what it produces.
- Accepts one instruction per handshake and reads two operands from an internal 8x8 register file (second operand may be an immediate).
- Presents the registered operands and opcode to the ULA, then latches its result and flags.
- Writes the result back to the destination register and signals completion.

Parameters:
REG_COUNT, 8, number of 8-bit registers (power of two)
REG_ADDR_W, 3, register index width, equals log2(REG_COUNT)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction present
in_ready  output  1  stage can accept an instruction
in_op  input  4  ULA opcode: [3]=ainvert, [2]=binvert+cin, [1:0]=00 AND, 01 OR, 10 ADD, 11 SLT
in_rd  input  REG_ADDR_W  destination register
in_rs  input  REG_ADDR_W  operand A register
in_rt  input  REG_ADDR_W  operand B register
in_imm_sel  input  1  1: operand B = in_imm, 0: operand B = reg[in_rt]
in_imm  input  8  immediate
alu_a  output  8  to ULA a
alu_b  output  8  to ULA b
alu_op  output  4  to ULA op
alu_result  input  8  from ULA result
alu_cout  input  1  from ULA cout
alu_overflow  input  1  from ULA overflow
alu_zero  input  1  from ULA zero
done  output  1  one-cycle pulse, writeback occurred
flag_zero  output  1  registered ULA zero of last completed op
flag_cout  output  1  registered ULA cout of last completed op
flag_ovf  output  1  registered ULA overflow of last completed op
dbg_addr  input  REG_ADDR_W  debug read index
dbg_data  output  8  combinational read of reg[dbg_addr]

Behaviour:
- Reset (async, rst_n=0): state IDLE; all registers 0; alu_a, alu_b, alu_op = 0; flags 0; done = 0; in_ready = 1 once rst_n is released.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch opA = reg[in_rs], opB = (in_imm_sel ? in_imm : reg[in_rt]), op and rd; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - in_ready = 0.
  - alu_a/alu_b/alu_op are driven from the latches, which are stable for the whole cycle; the ULA is purely combinational.
  - At the clock edge: capture alu_result into res_q and the three flags into flag_*; go to WB.
- WB:
  - in_ready = 0; done = 1 for exactly this cycle.
  - At the clock edge: reg[rd] <= res_q unless rd = 0; go to IDLE.
- Latency and throughput: accept edge to writeback edge is 2 cycles. done is high in the 2nd cycle after acceptance. Maximum throughput is one instruction per 3 cycles.
- Register 0:
  - Always reads 0.
  - Writes to it are discarded.
  - Flags and done still update normally.
- Hazards: the next accept happens only in IDLE, after writeback, so it always reads the updated value. No bypass is needed.
- in_valid while in_ready = 0 is ignored. The source must hold its instruction until the handshake completes.
- Flags:
  - Updated on every op.
  - cout and ovf are meaningful only for ADD/SUB/SLT; for AND/OR/NOR they take whatever the ULA reports.
  - Flags hold until the next EXEC.
- alu_* outputs keep their last values outside EXEC; they are not cleared.
- dbg_data is combinational. It reflects a writeback from the clock edge ending WB.
- rst_n asserted in EXEC or WB aborts the instruction: no writeback, no done, flags cleared.
- Opcodes used by the team: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.

Decomposition:
- Shared package:
  - opcode constants OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR;
  - FSM state encoding ST_IDLE, ST_EXEC, ST_WB (2 bits).
- One natural sub-module: ula_regfile. It holds REG_COUNT x 8 storage with two combinational read ports plus a debug port, one synchronous write port, r0 forced to zero, and async active-low clear.
- The FSM, operand latches and result/flag registers stay in ula_exec_stage.
- The bench instantiates the existing ULA and connects it to the alu_* ports.

Test Plan:
- Load and add: ADD rd=1 rs=0 imm=5, then ADD rd=2 rs=1 imm=3 -> dbg r1=5, r2=8; done pulses 2 cycles after each accept; flag_zero=0.
- Subtract to zero: SUB rd=3 rs=1 rt=1 with r1=5 -> r3=0, flag_zero=1, flag_cout=1.
- Signed overflow: r1=127, ADD imm=1 -> result 0x80, flag_ovf=1; then r1=200 (0xC8), ADD imm=100 -> result 44 (0x2C), flag_cout=1, flag_ovf=0.
- SLT and logic: r1=0xF0, r2=0x05: SLT rs=1 rt=2 -> 1; AND -> 0x00 with flag_zero=1; NOR -> 0x0A.
- r0 and handshake: ADD rd=0 imm=9 -> r0 stays 0, done still pulses; in_valid held high through EXEC/WB -> exactly one accept per 3 cycles, no duplicate writeback.
- Reset mid-operation: assert rst_n=0 during EXEC of ADD rd=4 imm=7 -> r4=0, flags 0, no done pulse; after release in_ready=1 and the next instruction completes normally.

Source files
------------

// File: rtl/ula_exec_stage_pkg.sv
// ----------------------------------------------------------------------------
// ula_exec_stage_pkg
// Shared definitions for the ULA execute/writeback stage:
//   - opcode constants understood by the downstream 8-bit ULA
//       op[3] = ainvert, op[2] = binvert + carry-in, op[1:0] = AND/OR/ADD/SLT
//   - FSM state encoding of the stage (2 bits)
//   - operand bundle presented to the ULA
// ----------------------------------------------------------------------------
package ula_exec_stage_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_WB   = 2'b10
   } state_t;

   // Operands and opcode latched at accept, held stable towards the ULA.
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
   } alu_req_t;

endpackage

// File: rtl/ula_exec_stage_if.sv
// ----------------------------------------------------------------------------
// ula_exec_stage_if
// Instruction handshake into the execute stage.
//   master : instruction source (drives in_valid and the instruction fields)
//   slave  : the execute stage (drives in_ready)
// An instruction is accepted on a rising clk edge with in_valid & in_ready.
// ----------------------------------------------------------------------------
interface ula_exec_stage_if #(
   parameter int REG_ADDR_W = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            in_op;
   logic [REG_ADDR_W-1:0] in_rd;
   logic [REG_ADDR_W-1:0] in_rs;
   logic [REG_ADDR_W-1:0] in_rt;
   logic                  in_imm_sel;
   logic [7:0]            in_imm;

   modport master (
      output in_valid, in_op, in_rd, in_rs, in_rt, in_imm_sel, in_imm,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm_sel, in_imm,
      output in_ready
   );
endinterface

// File: rtl/ula_exec_stage_regfile.sv
// ----------------------------------------------------------------------------
// ula_regfile
// REG_COUNT x 8-bit register file.
//   clk, rst_n          : clock, asynchronous active-low clear of all entries
//   we, waddr, wdata    : synchronous write port (writes to r0 discarded)
//   raddr_a / rdata_a   : combinational read port A
//   raddr_b / rdata_b   : combinational read port B
//   dbg_addr / dbg_data : combinational debug read port
// r0 always reads as zero.
// ----------------------------------------------------------------------------
module ula_regfile #(
   parameter int REG_COUNT  = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [7:0]            wdata,
   input  logic [REG_ADDR_W-1:0] raddr_a,
   output logic [7:0]            rdata_a,
   input  logic [REG_ADDR_W-1:0] raddr_b,
   output logic [7:0]            rdata_b,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [7:0]            dbg_data
);

   logic [7:0] mem_q [REG_COUNT];

   // NOTE: the storage is flops, not a RAM macro, so clearing every entry in
   // the async reset branch is legal and gives a known register file.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_a  = (raddr_a  == '0) ? 8'h00 : mem_q[raddr_a];
   assign rdata_b  = (raddr_b  == '0) ? 8'h00 : mem_q[raddr_b];
   assign dbg_data = (dbg_addr == '0) ? 8'h00 : mem_q[dbg_addr];

endmodule

// File: rtl/ula_exec_stage.sv
// ----------------------------------------------------------------------------
// ula_exec_stage
// Execute/writeback stage feeding an external combinational 8-bit ULA.
//   clk, rst_n     : clock, asynchronous active-low reset (aborts any op)
//   inst           : instruction handshake (slave side)
//   alu_a/b/op     : registered operands/opcode towards the ULA
//   alu_result/cout/overflow/zero : ULA outputs, captured at end of EXEC
//   done           : one-cycle pulse during the writeback cycle
//   flag_zero/cout/ovf : flags of the last completed op
//   dbg_addr/data  : combinational debug read of the register file
// Sequence: IDLE (accept) -> EXEC (ULA evaluates) -> WB (write rd) -> IDLE.
// ----------------------------------------------------------------------------
module ula_exec_stage
   import ula_exec_stage_pkg::*;
#(
   parameter int REG_COUNT  = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ula_exec_stage_if.slave       inst,
   output logic [7:0]            alu_a,
   output logic [7:0]            alu_b,
   output logic [3:0]            alu_op,
   input  logic [7:0]            alu_result,
   input  logic                  alu_cout,
   input  logic                  alu_overflow,
   input  logic                  alu_zero,
   output logic                  done,
   output logic                  flag_zero,
   output logic                  flag_cout,
   output logic                  flag_ovf,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [7:0]            dbg_data
);

   state_t                state_q, state_d;
   alu_req_t              req_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [7:0]            res_q;
   logic [7:0]            rs_data, rt_data;
   logic                  accept;

   ula_regfile #(
      .REG_COUNT  (REG_COUNT),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (done),
      .waddr    (rd_q),
      .wdata    (res_q),
      .raddr_a  (inst.in_rs),
      .rdata_a  (rs_data),
      .raddr_b  (inst.in_rt),
      .rdata_b  (rt_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first so no latch is
   // inferred on paths where a state does not assign it.
   always_comb begin
      state_d       = state_q;
      inst.in_ready = 1'b0;
      done          = 1'b0;
      accept        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            inst.in_ready = 1'b1;
            if (inst.in_valid) begin
               accept  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_WB;
         ST_WB: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand latches only change at accept, so the ULA inputs hold their
   // last values outside EXEC without any extra enable logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q     <= '0;
         rd_q      <= '0;
         res_q     <= '0;
         flag_zero <= 1'b0;
         flag_cout <= 1'b0;
         flag_ovf  <= 1'b0;
      end else begin
         if (accept) begin
            req_q.a  <= rs_data;
            req_q.b  <= inst.in_imm_sel ? inst.in_imm : rt_data;
            req_q.op <= inst.in_op;
            rd_q     <= inst.in_rd;
         end
         if (state_q == ST_EXEC) begin
            res_q     <= alu_result;
            flag_zero <= alu_zero;
            flag_cout <= alu_cout;
            flag_ovf  <= alu_overflow;
         end
      end
   end

   assign alu_a  = req_q.a;
   assign alu_b  = req_q.b;
   assign alu_op = req_q.op;

endmodule
